// File: rtl/tlul_source_remap.sv
// tlul_source_remap: TL-UL source-ID adapter from a wide host source to a narrow
// device source. Each request takes the lowest free device slot, and the slot
// remembers the host ID. The response gets its host ID back from the slot, and
// the slot is freed.
// Optional occupancy statistics are enabled by defining TLUL_SOURCE_REMAP_STATS_EN.
module tlul_source_remap #(
    parameter int HOST_SIW = 10,
    parameter int DEV_SIW  = 2,
    parameter int APW      = 104,
    parameter int DPW      = 80
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                h_a_valid_i,
    output logic                h_a_ready_o,
    input  logic [HOST_SIW-1:0] h_a_source_i,
    input  logic [APW-1:0]      h_a_payload_i,
    output logic                d_a_valid_o,
    input  logic                d_a_ready_i,
    output logic [DEV_SIW-1:0]  d_a_source_o,
    output logic [APW-1:0]      d_a_payload_o,
    input  logic                d_d_valid_i,
    output logic                d_d_ready_o,
    input  logic [DEV_SIW-1:0]  d_d_source_i,
    input  logic [DPW-1:0]      d_d_payload_i,
    output logic                h_d_valid_o,
    input  logic                h_d_ready_i,
    output logic [HOST_SIW-1:0] h_d_source_o,
    output logic [DPW-1:0]      h_d_payload_o,
    output logic                busy_o,
    output logic                err_o
`ifdef TLUL_SOURCE_REMAP_STATS_EN
    ,
    output logic [DEV_SIW:0]    occ_o,
    output logic [DEV_SIW:0]    occ_max_o
`endif
);

    localparam int NSLOT = 1 << DEV_SIW;

    logic [NSLOT-1:0]    vld_q;
    logic [NSLOT-1:0]    vld_d;
    logic [HOST_SIW-1:0] src_q [NSLOT];
    logic                err_q;
    logic                full;
    logic [DEV_SIW-1:0]  alloc_idx;
    logic                a_hs;
    logic                d_hs;
    logic                d_slot_live;

    assign full        = &vld_q;
    assign d_a_valid_o = h_a_valid_i & ~full;
    assign h_a_ready_o = d_a_ready_i & ~full;
    assign d_a_source_o  = alloc_idx;
    assign d_a_payload_o = h_a_payload_i;
    assign a_hs = d_a_valid_o & d_a_ready_i;

    assign h_d_valid_o   = d_d_valid_i;
    assign d_d_ready_o   = h_d_ready_i;
    assign h_d_payload_o = d_d_payload_i;
    assign d_hs = d_d_valid_i & h_d_ready_i;

    // A response to a free slot still passes, but carries host ID 0 rather than a stale ID
    assign d_slot_live  = vld_q[d_d_source_i];
    assign h_d_source_o = (d_d_valid_i && !d_slot_live) ? '0 : src_q[d_d_source_i];

    assign busy_o = |vld_q;
    assign err_o  = err_q;

    // Find the lowest free slot. Only registered state is used, so a same-cycle free does not feed back into A
    always_comb begin
        alloc_idx = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!vld_q[i]) alloc_idx = DEV_SIW'(i);
        end
    end

    // Next slot occupancy: the D free is applied first, then the A allocation
    always_comb begin
        vld_d = vld_q;
        if (d_hs) vld_d[d_d_source_i] = 1'b0;
        if (a_hs) vld_d[alloc_idx] = 1'b1;
    end

    // Slot valid bits and sticky error for responses to unallocated slots
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            err_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (d_hs && !d_slot_live) err_q <= 1'b1;
        end
    end

    // Host-ID table, written on each accepted request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NSLOT; i++) src_q[i] <= '0;
        end else if (a_hs) begin
            src_q[alloc_idx] <= h_a_source_i;
        end
    end

`ifdef TLUL_SOURCE_REMAP_STATS_EN
    function automatic logic [DEV_SIW:0] popcount(input logic [NSLOT-1:0] v);
        logic [DEV_SIW:0] c;
        c = '0;
        for (int i = 0; i < NSLOT; i++) c = c + {{DEV_SIW{1'b0}}, v[i]};
        return c;
    endfunction

    logic [DEV_SIW:0] occ_d;
    logic [DEV_SIW:0] occ_q;
    logic [DEV_SIW:0] occ_max_q;

    assign occ_d     = popcount(vld_d);
    assign occ_o     = occ_q;
    assign occ_max_o = occ_max_q;

    // Occupancy follows vld_q cycle for cycle; the watermark only ever rises until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q     <= '0;
            occ_max_q <= '0;
        end else begin
            occ_q <= occ_d;
            if (occ_d > occ_max_q) occ_max_q <= occ_d;
        end
    end
`endif

endmodule

// File: tb/tb_tlul_source_remap.sv
// Testbench for tlul_source_remap (default build). A slot-table reference model
// runs alongside the DUT and supplies the expected values. Directed scenarios are
// followed by a randomized traffic phase.
module tb_tlul_source_remap;

    localparam int HOST_SIW = 10;
    localparam int DEV_SIW  = 2;
    localparam int APW      = 104;
    localparam int DPW      = 80;
    localparam int NSLOT    = 4;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                h_a_valid_i = 1'b0;
    logic                h_a_ready_o;
    logic [HOST_SIW-1:0] h_a_source_i = '0;
    logic [APW-1:0]      h_a_payload_i = '0;
    logic                d_a_valid_o;
    logic                d_a_ready_i = 1'b0;
    logic [DEV_SIW-1:0]  d_a_source_o;
    logic [APW-1:0]      d_a_payload_o;
    logic                d_d_valid_i = 1'b0;
    logic                d_d_ready_o;
    logic [DEV_SIW-1:0]  d_d_source_i = '0;
    logic [DPW-1:0]      d_d_payload_i = '0;
    logic                h_d_valid_o;
    logic                h_d_ready_i = 1'b0;
    logic [HOST_SIW-1:0] h_d_source_o;
    logic [DPW-1:0]      h_d_payload_o;
    logic                busy_o;
    logic                err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: which slots hold a request, the host ID each holds, sticky error
    bit                  mv [NSLOT];
    logic [HOST_SIW-1:0] ms [NSLOT];
    bit                  merr;

    tlul_source_remap #(
        .HOST_SIW(HOST_SIW), .DEV_SIW(DEV_SIW), .APW(APW), .DPW(DPW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .h_a_valid_i(h_a_valid_i), .h_a_ready_o(h_a_ready_o),
        .h_a_source_i(h_a_source_i), .h_a_payload_i(h_a_payload_i),
        .d_a_valid_o(d_a_valid_o), .d_a_ready_i(d_a_ready_i),
        .d_a_source_o(d_a_source_o), .d_a_payload_o(d_a_payload_o),
        .d_d_valid_i(d_d_valid_i), .d_d_ready_o(d_d_ready_o),
        .d_d_source_i(d_d_source_i), .d_d_payload_i(d_d_payload_i),
        .h_d_valid_o(h_d_valid_o), .h_d_ready_i(h_d_ready_i),
        .h_d_source_o(h_d_source_o), .h_d_payload_o(h_d_payload_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bit m_full();
        for (int i = 0; i < NSLOT; i++) if (!mv[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_any();
        for (int i = 0; i < NSLOT; i++) if (mv[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < NSLOT; i++) if (!mv[i]) return i;
        return 0;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NSLOT; i++) begin
            mv[i] = 1'b0;
            ms[i] = '0;
        end
        merr = 1'b0;
    endtask

    // Advance one clock; the model takes the handshakes implied by the current inputs
    task automatic tick();
        bit a_hs;
        bit d_hs;
        int idx;
        int slot;
        logic [HOST_SIW-1:0] src;
        a_hs = h_a_valid_i && d_a_ready_i && !m_full();
        d_hs = d_d_valid_i && h_d_ready_i;
        idx  = m_free();
        slot = int'(d_d_source_i);
        src  = h_a_source_i;
        @(posedge clk_i);
        #1;
        if (d_hs) begin
            if (!mv[slot]) merr = 1'b1;
            mv[slot] = 1'b0;
        end
        if (a_hs) begin
            mv[idx] = 1'b1;
            ms[idx] = src;
        end
    endtask

    task automatic drive_a(input bit v, input logic [HOST_SIW-1:0] src);
        h_a_valid_i   = v;
        d_a_ready_i   = 1'b1;
        h_a_source_i  = src;
        h_a_payload_i = {$urandom, $urandom, $urandom, 8'($urandom)};
    endtask

    task automatic drive_d(input bit v, input int slot);
        d_d_valid_i   = v;
        h_d_ready_i   = 1'b1;
        d_d_source_i  = DEV_SIW'(slot);
        d_d_payload_i = {$urandom, $urandom, 16'($urandom)};
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        drive_a(1'b0, '0);
        drive_d(1'b0, 0);
        m_clear();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive_a(1'b1, 10'h3FF);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err_o); end
        checks++;
        if (d_a_valid_o !== 1'b1 || h_a_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_a_open: got v=%0b r=%0b want 1/1", d_a_valid_o, h_a_ready_o);
        end
        checks++;
        if (d_a_source_o !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", d_a_source_o); end
        drive_a(1'b0, '0);
    endtask

    task automatic test_single();
        drive_a(1'b1, 10'h2A5);
        #1;
        checks++;
        if (d_a_source_o !== 2'd0) begin errors++; $display("FAIL single_idx: got %0d want 0", d_a_source_o); end
        checks++;
        if (d_a_payload_o !== h_a_payload_i) begin errors++; $display("FAIL single_apayload: got %0h want %0h", d_a_payload_o, h_a_payload_i); end
        tick();
        drive_a(1'b0, '0);
        drive_d(1'b1, 0);
        #1;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b want 1", busy_o); end
        checks++;
        if (h_d_source_o !== 10'h2A5) begin errors++; $display("FAIL single_restore: got %0h want 2a5", h_d_source_o); end
        checks++;
        if (h_d_payload_o !== d_d_payload_i || h_d_valid_o !== 1'b1 || d_d_ready_o !== 1'b1) begin
            errors++; $display("FAIL single_dpass: got v=%0b r=%0b p=%0h want 1/1/%0h", h_d_valid_o, d_d_ready_o, h_d_payload_o, d_d_payload_i);
        end
        tick();
        drive_d(1'b0, 0);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b want 0", busy_o); end
    endtask

    task automatic test_fill_stall();
        for (int i = 0; i < NSLOT; i++) begin
            drive_a(1'b1, 10'h10 + 10'(i));
            #1;
            checks++;
            if (d_a_source_o !== DEV_SIW'(i)) begin errors++; $display("FAIL fill_idx%0d: got %0d want %0d", i, d_a_source_o, i); end
            tick();
        end
        drive_a(1'b1, 10'h055);
        #1;
        checks++;
        if (h_a_ready_o !== 1'b0 || d_a_valid_o !== 1'b0) begin
            errors++; $display("FAIL fill_stall: got r=%0b v=%0b want 0/0", h_a_ready_o, d_a_valid_o);
        end
        tick();
        drive_d(1'b1, 2);
        #1;
        checks++;
        if (h_d_source_o !== 10'h012) begin errors++; $display("FAIL fill_free2_src: got %0h want 12", h_d_source_o); end
        checks++;
        if (h_a_ready_o !== 1'b0) begin errors++; $display("FAIL fill_no_comb_unblock: got %0b want 0", h_a_ready_o); end
        tick();
        drive_d(1'b0, 0);
        #1;
        checks++;
        if (h_a_ready_o !== 1'b1 || d_a_source_o !== 2'd2) begin
            errors++; $display("FAIL fill_reuse2: got r=%0b idx=%0d want 1/2", h_a_ready_o, d_a_source_o);
        end
        tick();
        drive_a(1'b0, '0);
    endtask

    task automatic test_out_of_order();
        int order [4] = '{3, 0, 2, 1};
        for (int k = 0; k < 4; k++) begin
            drive_d(1'b1, order[k]);
            #1;
            checks++;
            if (h_d_source_o !== ms[order[k]]) begin
                errors++; $display("FAIL ooo_slot%0d: got %0h want %0h", order[k], h_d_source_o, ms[order[k]]);
            end
            tick();
        end
        drive_d(1'b0, 0);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL ooo_drained: got %0b want 0", busy_o); end
    endtask

    task automatic test_full_same_cycle();
        logic [HOST_SIW-1:0] s;
        for (int i = 0; i < NSLOT; i++) begin
            drive_a(1'b1, 10'($urandom));
            tick();
        end
        s = 10'($urandom);
        drive_a(1'b1, s);
        drive_d(1'b1, 1);
        #1;
        checks++;
        if (h_a_ready_o !== 1'b0 || d_a_valid_o !== 1'b0) begin
            errors++; $display("FAIL same_cycle_block: got r=%0b v=%0b want 0/0", h_a_ready_o, d_a_valid_o);
        end
        checks++;
        if (h_d_source_o !== ms[1]) begin errors++; $display("FAIL same_cycle_dsrc: got %0h want %0h", h_d_source_o, ms[1]); end
        tick();
        drive_d(1'b0, 0);
        #1;
        checks++;
        if (h_a_ready_o !== 1'b1 || d_a_source_o !== 2'd1) begin
            errors++; $display("FAIL same_cycle_next: got r=%0b idx=%0d want 1/1", h_a_ready_o, d_a_source_o);
        end
        tick();
        drive_a(1'b0, '0);
        for (int i = 0; i < NSLOT; i++) begin
            drive_d(1'b1, i);
            #1;
            checks++;
            if (h_d_source_o !== ms[i]) begin errors++; $display("FAIL same_cycle_drain%0d: got %0h want %0h", i, h_d_source_o, ms[i]); end
            tick();
        end
        drive_d(1'b0, 0);
    endtask

    task automatic test_unalloc();
        #1;
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL unalloc_pre: got %0b want 0", err_o); end
        drive_d(1'b1, 3);
        #1;
        checks++;
        if (h_d_source_o !== '0 || h_d_valid_o !== 1'b1) begin
            errors++; $display("FAIL unalloc_src: got src=%0h v=%0b want 0/1", h_d_source_o, h_d_valid_o);
        end
        tick();
        drive_d(1'b0, 0);
        repeat (3) tick();
        checks++;
        if (err_o !== merr || merr !== 1'b1) begin errors++; $display("FAIL unalloc_sticky: got %0b want 1", err_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive_a(1'b1, 10'($urandom));
            tick();
        end
        drive_a(1'b0, '0);
        #2;
        rst_ni = 1'b0;
        m_clear();
        #1;
        checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL midrst_clear: got busy=%0b err=%0b want 0/0", busy_o, err_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        drive_a(1'b1, 10'h1C3);
        #1;
        checks++;
        if (d_a_source_o !== 2'd0) begin errors++; $display("FAIL midrst_slot0: got %0d want 0", d_a_source_o); end
        tick();
        drive_a(1'b0, '0);
        drive_d(1'b1, 1);
        tick();
        drive_d(1'b0, 0);
        #1;
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL midrst_stale_err: got %0b want 1", err_o); end
    endtask

    task automatic test_random();
        int slot;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            h_a_valid_i   = 1'($urandom);
            d_a_ready_i   = ($urandom_range(0, 3) != 0);
            h_a_source_i  = 10'($urandom);
            h_a_payload_i = {$urandom, $urandom, $urandom, 8'($urandom)};
            h_d_ready_i   = 1'($urandom);
            d_d_payload_i = {$urandom, $urandom, 16'($urandom)};
            d_d_valid_i   = 1'b0;
            slot = -1;
            if (m_any() && $urandom_range(0, 2) != 0) begin
                for (int t = 0; t < 16 && slot < 0; t++) begin
                    int s = $urandom_range(0, NSLOT - 1);
                    if (mv[s]) slot = s;
                end
            end
            if (slot >= 0) begin
                d_d_valid_i  = 1'b1;
                d_d_source_i = DEV_SIW'(slot);
            end
            #1;
            checks++;
            if (d_a_valid_o !== (h_a_valid_i && !m_full()) || h_a_ready_o !== (d_a_ready_i && !m_full())) begin
                errors++; $display("FAIL rnd_a_flow c%0d: got v=%0b r=%0b full=%0b", c, d_a_valid_o, h_a_ready_o, m_full());
            end
            if (!m_full()) begin
                checks++;
                if (d_a_source_o !== DEV_SIW'(m_free())) begin
                    errors++; $display("FAIL rnd_idx c%0d: got %0d want %0d", c, d_a_source_o, m_free());
                end
            end
            if (slot >= 0) begin
                checks++;
                if (h_d_source_o !== ms[slot]) begin
                    errors++; $display("FAIL rnd_dsrc c%0d: got %0h want %0h", c, h_d_source_o, ms[slot]);
                end
            end
            checks++;
            if (busy_o !== m_any() || err_o !== merr) begin
                errors++; $display("FAIL rnd_status c%0d: got busy=%0b err=%0b want %0b/%0b", c, busy_o, err_o, m_any(), merr);
            end
            checks++;
            if (d_a_payload_o !== h_a_payload_i || h_d_payload_o !== d_d_payload_i) begin
                errors++; $display("FAIL rnd_payload c%0d: got a=%0h d=%0h", c, d_a_payload_o, h_d_payload_o);
            end
            tick();
        end
        drive_a(1'b0, '0);
        drive_d(1'b0, 0);
    endtask

    initial begin
        m_clear();
        test_reset();
        test_single();
        test_fill_stall();
        test_out_of_order();
        test_full_same_cycle();
        test_unalloc();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
